// File: rtl/polar_pkg.sv
// -----------------------------------------------------------------------------
// polar_pkg
//   Shared constants and helpers for the 1024-bit SC polar decoder datapath.
//   LEAF_W   : leaf decision width (also the PSC layer-1 node count)
//   LVL_NUM  : number of combine levels (PSC layer count); 2**LVL_NUM leaves
//   N        : codeword length
//   LVL_W    : width of a combine-depth value (0..LVL_NUM)
//   SLOT_W   : total width of the left-sibling slot bank (slots 0..LVL_NUM-1)
// -----------------------------------------------------------------------------
package polar_pkg;

    localparam int unsigned LEAF_W  = 16;
    localparam int unsigned LVL_NUM = 6;
    localparam int unsigned N       = LEAF_W << LVL_NUM;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned SLOT_W  = LEAF_W * ((1 << LVL_NUM) - 1);

    // Number of consecutive ones starting from bit 0.
    function automatic logic [LVL_W-1:0] trailing_ones6(input logic [5:0] t);
        logic [LVL_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (run && t[i]) n = n + 1'b1;
            else             run = 1'b0;
        end
        return n;
    endfunction

    // N-bit vector with the low w bits set; w >= N gives all ones.
    function automatic logic [N-1:0] low_mask(input int unsigned w);
        logic [N-1:0] ones;
        ones = '1;
        return ~(ones << w);
    endfunction

endpackage

// File: rtl/psum_ctrl_psc.sv
// -----------------------------------------------------------------------------
// psum_ctrl_psc
//   Combinational partial-sum combine array (PSC). Layer k (1..LVL_NUM) pairs
//   the running value in the low 16<<(k-1) bits with the next 16<<(k-1) bits:
//   enabled gives upper ^= lower (x1 = u1^u0, x0 = u0), disabled passes through.
// Ports
//   sel_i    [LVL_NUM-1:0] layer enables, MSB = layer 1
//   b_in1_i  [N/2-1:0]     upper half of the input vector
//   b_in0_i  [N/2-1:0]     lower half of the input vector
//   b_out_o  [N-1:0]       combined vector
// -----------------------------------------------------------------------------
module psum_ctrl_psc
    import polar_pkg::*;
(
    input  logic [LVL_NUM-1:0] sel_i,
    input  logic [N/2-1:0]     b_in1_i,
    input  logic [N/2-1:0]     b_in0_i,
    output logic [N-1:0]       b_out_o
);

    logic [N-1:0] x;

    always_comb begin
        x = {b_in1_i, b_in0_i};
        for (int unsigned k = 0; k < LVL_NUM; k++) begin
            // Low half of each node is shifted onto its upper partner and XORed in.
            if (sel_i[LVL_NUM-1-k]) begin
                x = x ^ ((x & low_mask(LEAF_W << k)) << (LEAF_W << k));
            end
        end
        b_out_o = x;
    end

endmodule

// File: rtl/psum_ctrl.sv
// -----------------------------------------------------------------------------
// psum_ctrl
//   Partial-sum controller upstream of the PSC array. Accepts 16-bit leaf
//   decisions in leaf order, banks left-sibling partial sums per level, and
//   registers the combined partial sum (combine depth = trailing ones of the
//   leaf index). Leaf 63 yields the full re-encoded codeword with cw_vld.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   frame_start   1-cycle pulse: restart at leaf 0, clear slot bank
//   leaf_vld/rdy  leaf handshake; leaf_beta carries the 16 decided bits
//   psum_vld/rdy  partial-sum handshake; psum_lvl = combine depth
//   psum_data     partial sum, low 16<<psum_lvl bits meaningful, rest zero
//   cw_vld        1-cycle pulse with the final codeword on psum_data
// -----------------------------------------------------------------------------
module psum_ctrl
    import polar_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              leaf_vld,
    output logic              leaf_rdy,
    input  logic [LEAF_W-1:0] leaf_beta,
    output logic              psum_vld,
    input  logic              psum_rdy,
    output logic [LVL_W-1:0]  psum_lvl,
    output logic [N-1:0]      psum_data,
    output logic              cw_vld
);

    logic [LVL_NUM-1:0] leaf_idx_q, leaf_idx_d;
    logic [SLOT_W-1:0]  slots_q, slots_d;
    logic               psum_vld_q, psum_vld_d;
    logic [LVL_W-1:0]   psum_lvl_q, psum_lvl_d;
    logic [N-1:0]       psum_data_q, psum_data_d;
    logic               cw_vld_q, cw_vld_d;

    logic               accept;
    logic [LVL_NUM-1:0] idx_eff;
    logic [LVL_W-1:0]   lvl;
    logic [LVL_NUM-1:0] sel;
    logic [N-1:0]       b_out;
    logic [N-1:0]       res;
    logic [SLOT_W-1:0]  fld_mask;
    int unsigned        slot_ofs;

    assign leaf_rdy = !psum_vld_q || psum_rdy;
    assign accept   = leaf_vld && leaf_rdy;

    // A leaf arriving with frame_start is leaf 0 of the new frame.
    assign idx_eff  = frame_start ? '0 : leaf_idx_q;
    assign lvl      = trailing_ones6(idx_eff);
    assign sel      = ~({LVL_NUM{1'b1}} >> lvl);

    // Slot bank layout: slot_k occupies [LEAF_W*(2**k-1) +: LEAF_W<<k], so
    // {slots, leaf} lines up with the PSC input vector.
    psum_ctrl_psc u_psc (
        .sel_i   (sel),
        .b_in1_i (slots_q[SLOT_W-1 -: N/2]),
        .b_in0_i ({slots_q[N/2-LEAF_W-1:0], leaf_beta}),
        .b_out_o (b_out)
    );

    assign res = b_out & low_mask(LEAF_W << lvl);

    always_comb begin
        fld_mask = SLOT_W'(low_mask(LEAF_W << lvl));
        slot_ofs = LEAF_W * ((32'd1 << lvl) - 32'd1);
        slots_d  = frame_start ? '0 : slots_q;
        // Variable-width slot write: clear the slot_c field, then OR in the result.
        if (accept && (lvl < LVL_W'(LVL_NUM))) begin
            slots_d = (slots_d & ~(fld_mask << slot_ofs)) | (SLOT_W'(res) << slot_ofs);
        end
    end

    always_comb begin
        leaf_idx_d  = frame_start ? '0 : leaf_idx_q;
        psum_lvl_d  = psum_lvl_q;
        psum_data_d = psum_data_q;
        if (accept) begin
            leaf_idx_d  = idx_eff + 1'b1;
            psum_lvl_d  = lvl;
            psum_data_d = res;
        end
        // frame_start drops a pending output unless it brings a new leaf.
        psum_vld_d = accept || (!frame_start && psum_vld_q && !psum_rdy);
        cw_vld_d   = accept && (lvl == LVL_W'(LVL_NUM));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leaf_idx_q  <= '0;
            slots_q     <= '0;
            psum_vld_q  <= 1'b0;
            psum_lvl_q  <= '0;
            psum_data_q <= '0;
            cw_vld_q    <= 1'b0;
        end else begin
            leaf_idx_q  <= leaf_idx_d;
            slots_q     <= slots_d;
            psum_vld_q  <= psum_vld_d;
            psum_lvl_q  <= psum_lvl_d;
            psum_data_q <= psum_data_d;
            cw_vld_q    <= cw_vld_d;
        end
    end

    assign psum_vld  = psum_vld_q;
    assign psum_lvl  = psum_lvl_q;
    assign psum_data = psum_data_q;
    assign cw_vld    = cw_vld_q;

endmodule

// File: tb/tb_psum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psum_ctrl
//   Scoreboard bench for psum_ctrl: each accepted leaf pushes the expected
//   partial sum (polar transform of the frame's leaf history); outputs are
//   compared while valid and popped on the psum handshake.
// -----------------------------------------------------------------------------
module tb_psum_ctrl;
    import polar_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_start = 1'b0;
    logic              leaf_vld = 1'b0;
    logic              leaf_rdy;
    logic [LEAF_W-1:0] leaf_beta = '0;
    logic              psum_vld;
    logic              psum_rdy = 1'b0;
    logic [LVL_W-1:0]  psum_lvl;
    logic [N-1:0]      psum_data;
    logic              cw_vld;

    always #5 clk = ~clk;

    psum_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .leaf_vld    (leaf_vld),
        .leaf_rdy    (leaf_rdy),
        .leaf_beta   (leaf_beta),
        .psum_vld    (psum_vld),
        .psum_rdy    (psum_rdy),
        .psum_lvl    (psum_lvl),
        .psum_data   (psum_data),
        .cw_vld      (cw_vld)
    );

    typedef struct {
        logic [LVL_W-1:0] lvl;
        logic [N-1:0]     data;
    } exp_t;

    exp_t              sb[$];
    logic [LEAF_W-1:0] hist [64];
    int unsigned       m_idx = 0;
    logic              m_vld = 1'b0;
    logic              m_cw  = 1'b0;
    int                n_chk = 0;
    int                n_pass = 0;
    int                cw_seen = 0;
    int                n_acc = 0;
    int                n_pop = 0;

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        int unsigned fb;
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            fb = 0;
            for (int i = N - 1; i >= 0; i--) if (got[i] !== exp[i]) fb = i;
            $display("FAIL %s: got=%h exp=%h (low 128 bits, first diff bit %0d)",
                     tag, got[127:0], exp[127:0], fb);
        end
    endtask

    // Combine depth: number of times 2 divides t+1 (capped at LVL_NUM).
    function automatic int unsigned model_lvl(input int unsigned t);
        int unsigned v, c;
        v = t + 1;
        c = 0;
        while ((v % 2 == 0) && (c < LVL_NUM)) begin
            v = v / 2;
            c++;
        end
        return c;
    endfunction

    // Newest leaf at the bottom; each stage XORs a lower half onto its upper half.
    function automatic logic [N-1:0] model_psum(input int unsigned t, input int unsigned c);
        logic [N-1:0] x;
        int unsigned  h;
        x = '0;
        for (int unsigned p = 0; p < (32'd1 << c); p++) x[LEAF_W*p +: LEAF_W] = hist[t-p];
        for (int unsigned s = 0; s < c; s++) begin
            h = LEAF_W << s;
            for (int unsigned b = 0; b < N; b++) if ((b / h) % 2 == 1) x[b] = x[b] ^ x[b-h];
        end
        return x;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_vld = 1'b0;
        m_cw  = 1'b0;
        m_idx = 0;
        foreach (hist[i]) hist[i] = '0;
    endtask

    // One clock: drive at negedge, check settled outputs, advance the model.
    task automatic cycle(input logic fs, input logic vld, input logic [LEAF_W-1:0] beta,
                         input logic rdy);
        logic        exp_rdy;
        logic        acc;
        int unsigned c;
        frame_start = fs;
        leaf_vld    = vld;
        leaf_beta   = beta;
        psum_rdy    = rdy;
        #1;
        exp_rdy = !m_vld || rdy;
        check_eq("leaf_rdy", N'(leaf_rdy), N'(exp_rdy));
        check_eq("psum_vld", N'(psum_vld), N'(m_vld));
        check_eq("cw_vld", N'(cw_vld), N'(m_cw));
        if (cw_vld === 1'b1) cw_seen++;
        if (m_vld && sb.size() != 0) begin
            check_eq("psum_lvl", N'(psum_lvl), N'(sb[0].lvl));
            check_eq("psum_data", psum_data, sb[0].data);
        end
        if (m_vld && (rdy || fs)) begin
            void'(sb.pop_front());
            if (rdy) n_pop++;
        end
        acc = vld && exp_rdy;
        if (fs) begin
            m_idx = 0;
            foreach (hist[i]) hist[i] = '0;
        end
        m_vld = acc || (!fs && m_vld && !rdy);
        m_cw  = 1'b0;
        if (acc) begin
            hist[m_idx] = beta;
            c = model_lvl(m_idx);
            sb.push_back('{lvl: LVL_W'(c), data: model_psum(m_idx, c)});
            m_cw  = (c == LVL_NUM);
            n_acc++;
            m_idx = (m_idx + 1) % 64;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #2;
        rst         = 1'b1;
        frame_start = 1'b0;
        leaf_vld    = 1'b0;
        psum_rdy    = 1'b0;
        #1;
        check_eq("rst_psum_vld", N'(psum_vld), '0);
        check_eq("rst_cw_vld", N'(cw_vld), '0);
        check_eq("rst_psum_data", psum_data, '0);
        check_eq("rst_psum_lvl", N'(psum_lvl), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_leaf_rdy", N'(leaf_rdy), N'(1'b1));
        model_clear();
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && m_vld; k++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Two back-to-back leaves after reset.
        cycle(1'b0, 1'b1, 16'h0001, 1'b1);
        check_eq("t2_l0_data", psum_data, N'(16'h0001));
        check_eq("t2_l0_lvl", N'(psum_lvl), N'(3'd0));
        cycle(1'b0, 1'b1, 16'h0002, 1'b1);
        check_eq("t2_l1_data", psum_data, N'(32'h0003_0002));
        check_eq("t2_l1_lvl", N'(psum_lvl), N'(3'd1));

        // Full frame of all-ones leaves: codeword collapses to the low leaf.
        cw_seen = 0;
        cycle(1'b1, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 1; i < 64; i++) cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
        check_eq("t3_cw_pulse", N'(cw_vld), N'(1'b1));
        check_eq("t3_cw_lvl", N'(psum_lvl), N'(3'd6));
        check_eq("t3_cw_data", psum_data, N'(16'hFFFF));
        cycle(1'b0, 1'b1, 16'h1234, 1'b1);
        check_eq("t3_wrap_lvl", N'(psum_lvl), N'(3'd0));
        check_eq("t3_wrap_data", psum_data, N'(16'h1234));
        drain();
        check_eq("t3_cw_count", N'(cw_seen), N'(1));

        // Random leaves under random backpressure.
        n_acc = 0;
        n_pop = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, ($urandom_range(0, 99) < 75), LEAF_W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        check_eq("t4_sb_empty", N'(sb.size()), '0);
        check_eq("t4_acc_vs_pop", N'(n_pop), N'(n_acc));

        // Reset while a stalled output is pending.
        cycle(1'b0, 1'b1, 16'hABCD, 1'b0);
        do_reset();
        cycle(1'b0, 1'b1, 16'h5A5A, 1'b1);
        check_eq("t1_after_rst_data", psum_data, N'(16'h5A5A));

        // frame_start after leaf 37 together with a leaf.
        cycle(1'b1, 1'b1, LEAF_W'($urandom), 1'b1);
        for (int i = 1; i <= 37; i++) cycle(1'b0, 1'b1, LEAF_W'($urandom), 1'b1);
        cycle(1'b1, 1'b1, 16'hC3C3, 1'b1);
        check_eq("t5_fs_lvl", N'(psum_lvl), N'(3'd0));
        check_eq("t5_fs_data", psum_data, N'(16'hC3C3));
        cycle(1'b0, 1'b1, 16'h0F0F, 1'b1);
        check_eq("t5_next_lvl", N'(psum_lvl), N'(3'd1));
        check_eq("t5_next_data", psum_data, N'(32'hCCCC_0F0F));
        // frame_start alone drops a stalled output.
        cycle(1'b0, 1'b1, 16'h7777, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset after leaf 20, then a complete frame.
        cw_seen = 0;
        cycle(1'b1, 1'b1, LEAF_W'($urandom), 1'b1);
        for (int i = 1; i <= 20; i++) cycle(1'b0, 1'b1, LEAF_W'($urandom), 1'b1);
        do_reset();
        check_eq("t6_no_cw", N'(cw_seen), '0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, LEAF_W'($urandom), 1'b1);
        drain();
        check_eq("t6_cw_count", N'(cw_seen), N'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
